// File: rtl/i2s_dac_receiver.sv
// Oversampling receiver for a left-justified / I2S DAC serial stream (BCLK, DACLRCK, DACDAT).
// Define I2S_DAC_RECEIVER_ERRCNT_EN to add the saturating err_count output.
module i2s_dac_receiver #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned I2S_DELAY = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bclk,
  input  logic             lrck,
  input  logic             dacdat,
  input  logic             err_clear,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic [1:0]       sample_end,
  output logic             sample_valid,
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
  output logic [7:0]       err_count,
`endif
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StSkip, StShift, StHold} state_e;

  state_e            state_q, state_d, st_eff;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              chan_q, chan_d;
  logic              left_seen_q;
  logic [1:0]        warm_q;
  logic [2:0]        bclk_sr, lrck_sr, dat_sr;
  logic              bclk_rise, lrck_edge, din;
  logic              word_done, short_ev;

  // [0],[1] synchronize; [2] is the delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
      dat_sr  <= '0;
      warm_q  <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], bclk};
      lrck_sr <= {lrck_sr[1:0], lrck};
      dat_sr  <= {dat_sr[1:0], dacdat};
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Mask the artificial LRCK edge produced while the cleared synchronizer fills after reset.
  assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
  assign lrck_edge = (warm_q == 2'd3) & (lrck_sr[1] ^ lrck_sr[2]);
  assign din       = dat_sr[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    chan_d    = chan_q;
    word_done = 1'b0;
    short_ev  = 1'b0;
    st_eff    = state_q;
    // The LRCK edge is handled first so a coincident BCLK rise belongs to the new word.
    if (lrck_edge) begin
      if (state_q == StShift && cnt_q < CntW'(WIDTH)) short_ev = 1'b1;
      cnt_d   = '0;
      chan_d  = lrck_sr[1];
      st_eff  = (I2S_DELAY != 0) ? StSkip : StShift;
      state_d = st_eff;
    end
    if (bclk_rise) begin
      unique case (st_eff)
        StSkip:  state_d = StShift;
        StShift: begin
          shreg_d = {shreg_q[WIDTH-2:0], din};
          cnt_d   = cnt_d + CntW'(1);
          if (cnt_d == CntW'(WIDTH)) begin
            word_done = 1'b1;
            state_d   = StHold;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      chan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      chan_q  <= chan_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_end   <= '0;
      sample_valid <= 1'b0;
      left_seen_q  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_end   <= '0;
      sample_valid <= 1'b0;
      if (word_done) begin
        if (chan_d) begin
          left_sample <= shreg_d;
          sample_end  <= 2'b10;
          left_seen_q <= 1'b1;
        end else begin
          right_sample <= shreg_d;
          sample_end   <= 2'b01;
          sample_valid <= left_seen_q;
          left_seen_q  <= 1'b0;
        end
      end
      if (err_clear)     frame_err <= 1'b0;
      else if (short_ev) frame_err <= 1'b1;
    end
  end

`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (short_ev && err_count != 8'hff) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dac_receiver.sv
// Scoreboard bench for i2s_dac_receiver: a left-justified instance and an I2S-delay instance.
module tb_i2s_dac_receiver;

  typedef struct packed {
    logic        right;
    logic [15:0] data;
    logic        valid;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_clear = 1'b0;
  logic b0 = 1'b0, l0 = 1'b0, d0 = 1'b0;
  logic b1 = 1'b0, l1 = 1'b0, d1 = 1'b0;
  logic [15:0] ls0, rs0, ls1, rs1;
  logic [1:0]  se0, se1;
  logic        sv0, sv1, fe0, fe1;
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
  logic [7:0]  ec0, ec1;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tgt     = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  always #5 clk = ~clk;

  i2s_dac_receiver #(.WIDTH(16), .I2S_DELAY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .bclk(b0), .lrck(l0), .dacdat(d0), .err_clear(err_clear),
    .left_sample(ls0), .right_sample(rs0), .sample_end(se0), .sample_valid(sv0),
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    .err_count(ec0),
`endif
    .frame_err(fe0)
  );

  i2s_dac_receiver #(.WIDTH(16), .I2S_DELAY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .bclk(b1), .lrck(l1), .dacdat(d1), .err_clear(err_clear),
    .left_sample(ls1), .right_sample(rs1), .sample_end(se1), .sample_valid(sv1),
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    .err_count(ec1),
`endif
    .frame_err(fe1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One BCLK period = 8 clk periods; LRCK and data change while BCLK is low.
  task automatic bit_out(input logic lr, input logic d);
    if (tgt == 0) begin l0 = lr; d0 = d; end else begin l1 = lr; d1 = d; end
    #40;
    if (tgt == 0) b0 = 1'b1; else b1 = 1'b1;
    #40;
    if (tgt == 0) b0 = 1'b0; else b1 = 1'b0;
  endtask

  task automatic send_word(input logic lr, input logic [15:0] w, input int from, input int upto,
                           input int pad, input bit stray);
    if (stray) bit_out(lr, ~w[15]);
    for (int i = from; i < upto; i++) bit_out(lr, w[15-i]);
    for (int i = 0; i < pad; i++) bit_out(lr, 1'b1);
  endtask

  task automatic expect_ev(input int id, input logic right, input logic [15:0] data,
                           input logic valid);
    ev_t e;
    e.right = right;
    e.data  = data;
    e.valid = valid;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic monitor(input int id, input logic [1:0] se, input logic [15:0] ls,
                         input logic [15:0] rs, input logic sv);
    ev_t e;
    int  sz;
    if (se == 2'b00 && sv) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d stray sample_valid: got 1, expected 0", id);
    end else if (se != 2'b00) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d unexpected sample_end: got %b, expected none", id, se);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d sample_end", id), {30'd0, se}, e.right ? 32'd1 : 32'd2);
        chk($sformatf("dut%0d sample data", id), {16'd0, e.right ? rs : ls}, {16'd0, e.data});
        chk($sformatf("dut%0d sample_valid", id), {31'd0, sv}, {31'd0, e.valid});
      end
    end
  endtask

  always @(negedge clk) monitor(0, se0, ls0, rs0, sv0);
  always @(negedge clk) monitor(1, se1, ls1, rs1, sv1);

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("reset left_sample", {16'd0, ls0}, 32'd0);
    chk("reset right_sample", {16'd0, rs0}, 32'd0);
    chk("reset sample_end", {30'd0, se0}, 32'd0);
    chk("reset frame_err", {31'd0, fe0}, 32'd0);
    chk("reset i2s left_sample", {16'd0, ls1}, 32'd0);
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    chk("reset err_count", {24'd0, ec0}, 32'd0);
`endif
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic left-justified frame
    expect_ev(0, 1'b0, 16'hA5C3, 1'b0);
    send_word(1'b1, 16'hA5C3, 0, 16, 0, 1'b0);
    expect_ev(0, 1'b1, 16'h0F01, 1'b1);
    send_word(1'b0, 16'h0F01, 0, 16, 0, 1'b0);
    settle();
    chk("basic left_sample", {16'd0, ls0}, 32'hA5C3);
    chk("basic right_sample", {16'd0, rs0}, 32'h0F01);
    chk("basic frame_err", {31'd0, fe0}, 32'd0);

    // 32 BCLKs per channel, padding of 1s ignored
    expect_ev(0, 1'b0, 16'h1234, 1'b0);
    send_word(1'b1, 16'h1234, 0, 16, 16, 1'b0);
    expect_ev(0, 1'b1, 16'h5678, 1'b1);
    send_word(1'b0, 16'h5678, 0, 16, 16, 1'b0);
    settle();
    chk("pad left_sample", {16'd0, ls0}, 32'h1234);

    // Right word truncated after 10 bits, then a good frame
    expect_ev(0, 1'b0, 16'hABCD, 1'b0);
    send_word(1'b1, 16'hABCD, 0, 16, 0, 1'b0);
    send_word(1'b0, 16'hFFC0, 0, 10, 0, 1'b0);
    expect_ev(0, 1'b0, 16'h0001, 1'b0);
    send_word(1'b1, 16'h0001, 0, 16, 0, 1'b0);
    settle();
    chk("short frame_err", {31'd0, fe0}, 32'd1);
    chk("short right_sample held", {16'd0, rs0}, 32'h5678);
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    chk("short err_count", {24'd0, ec0}, 32'd1);
`endif
    expect_ev(0, 1'b1, 16'h0002, 1'b1);
    send_word(1'b0, 16'h0002, 0, 16, 0, 1'b0);
    settle();
    chk("recover right_sample", {16'd0, rs0}, 32'h0002);

    // err_clear held across a short-frame event: clear wins
    pulse_clear();
    chk("clear frame_err", {31'd0, fe0}, 32'd0);
    send_word(1'b1, 16'h5555, 0, 5, 0, 1'b0);
    err_clear = 1'b1;
    expect_ev(0, 1'b1, 16'h1111, 1'b0);
    send_word(1'b0, 16'h1111, 0, 16, 0, 1'b0);
    err_clear = 1'b0;
    settle();
    chk("clear-wins frame_err", {31'd0, fe0}, 32'd0);
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    chk("clear-wins err_count", {24'd0, ec0}, 32'd0);
`endif

    // Reset in the middle of a left word
    send_word(1'b1, 16'hFFFF, 0, 8, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset left_sample", {16'd0, ls0}, 32'd0);
    chk("midreset right_sample", {16'd0, rs0}, 32'd0);
    chk("midreset sample_end", {30'd0, se0}, 32'd0);
    chk("midreset sample_valid", {31'd0, sv0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send_word(1'b1, 16'hFFFF, 8, 16, 0, 1'b0);
    expect_ev(0, 1'b1, 16'h0000, 1'b0);
    send_word(1'b0, 16'h0000, 0, 16, 0, 1'b0);
    expect_ev(0, 1'b0, 16'hFFFF, 1'b0);
    send_word(1'b1, 16'hFFFF, 0, 16, 0, 1'b0);
    expect_ev(0, 1'b1, 16'h0000, 1'b1);
    send_word(1'b0, 16'h0000, 0, 16, 0, 1'b0);
    settle();
    chk("postreset left_sample", {16'd0, ls0}, 32'hFFFF);
    chk("postreset frame_err", {31'd0, fe0}, 32'd0);

    // I2S instance: leading stray bit must be skipped
    tgt = 1;
    expect_ev(1, 1'b0, 16'h8001, 1'b0);
    send_word(1'b1, 16'h8001, 0, 16, 0, 1'b1);
    expect_ev(1, 1'b1, 16'h7FFE, 1'b1);
    send_word(1'b0, 16'h7FFE, 0, 16, 0, 1'b1);
    settle();
    chk("i2s left_sample", {16'd0, ls1}, 32'h8001);
    chk("i2s right_sample", {16'd0, rs1}, 32'h7FFE);
    chk("i2s frame_err", {31'd0, fe1}, 32'd0);

    // 300 one-bit channels: 299 short-frame events
    tgt = 0;
    for (int i = 0; i < 300; i++) bit_out((i % 2) == 0, 1'b0);
    settle();
    chk("burst frame_err", {31'd0, fe0}, 32'd1);
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    chk("burst err_count saturates", {24'd0, ec0}, 32'd255);
`endif
    pulse_clear();
    chk("final clear frame_err", {31'd0, fe0}, 32'd0);
`ifdef I2S_DAC_RECEIVER_ERRCNT_EN
    chk("final clear err_count", {24'd0, ec0}, 32'd0);
`endif
    settle();
    chk("dut0 missing events", q0.size(), 32'd0);
    chk("dut1 missing events", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_receiver.md
Name: i2s_dac_receiver

Overview:
- Codec-side receiver for the serial DAC stream produced by our audio codec interface (BCLK / DACLRCK / DACDAT).
- Oversamples the three serial lines in the local clock domain and deserializes each frame into left and right samples.
- Flags malformed frames.
- Used as the bench model of the WM8731 DAC port, and on-chip for loopback and monitoring of the audio output path.

Parameters:
- WIDTH, 16, bits per channel sample.
- I2S_DELAY, 0, 0 = left-justified (MSB in the first BCLK after the LRCK edge); 1 = I2S (MSB in the second BCLK).

Ports:
- clk  in  1  system clock; must run at least 4x the BCLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- bclk  in  1  serial bit clock; asynchronous to clk.
- lrck  in  1  DACLRCK; high = left channel, low = right channel; asynchronous.
- dacdat  in  1  serial data, MSB first; asynchronous.
- left_sample  out  WIDTH  last complete left word.
- right_sample  out  WIDTH  last complete right word.
- sample_end  out  2  one-cycle pulses: [1] left word done, [0] right word done.
- sample_valid  out  1  one-cycle pulse when a full left+right frame is done.
- frame_err  out  1  sticky; set when an LRCK edge arrives with fewer than WIDTH bits captured.
- err_clear  in  1  synchronous clear of frame_err; clear wins over a simultaneous set.

Behaviour:
- Synchronization:
  - bclk, lrck and dacdat each pass through a 2-flop synchronizer, followed by one delay flop for edge detection.
  - A BCLK rise (or LRCK edge) is detected 3 clk cycles after the pin transition.
- Sampling:
  - dacdat is sampled on detected BCLK rising edges only.
  - LRCK edges are acted on in the same cycle as a coincident BCLK rise, before that bit is shifted in.
- State machine:
  - IDLE: after reset, ignore all bits until the first LRCK edge; then go to SKIP if I2S_DELAY=1, else to SHIFT.
  - SKIP: discard exactly one BCLK rise, then go to SHIFT.
  - SHIFT: shift dacdat into the MSB-first shift register on each BCLK rise and increment a bit counter. When the counter reaches WIDTH, complete the word and go to HOLD.
  - HOLD: ignore further BCLK rises (padding bits); the next LRCK edge starts a new word via SKIP or SHIFT.
- Word completion (registered 1 cycle after the capturing BCLK-rise detect):
  - The channel is the lrck level latched at the start of the word.
  - Left word: left_sample is updated and sample_end[1] pulses.
  - Right word: right_sample is updated and sample_end[0] pulses.
  - sample_valid pulses together with sample_end[0] only if a left word completed since the last right word. A right word without a preceding left word gives sample_end[0] only.
- Short frame:
  - An LRCK edge while in SHIFT with fewer than WIDTH bits sets frame_err.
  - The partial word is discarded: the output registers are unchanged and no pulses are generated.
  - The new word then starts normally.
- Bit counter: width is clog2(WIDTH+1); it does not wrap; it is cleared on every LRCK edge.
- Reset:
  - Clears all outputs to 0, the synchronizers to 0, and the state to IDLE.
  - Reset asserted mid-word aborts the word silently; frame_err stays 0.
- Outputs are registered; there are no combinational paths from input ports to outputs.

Optional Feature:
- Macro: I2S_DAC_RECEIVER_ERRCNT_EN.
- When defined:
  - Adds output err_count [7:0], reset 0.
  - Increments on every short-frame event and saturates at 255.
  - Cleared by err_clear; clear wins over a simultaneous increment.
- When undefined: the port and counter are absent, and frame_err behaviour is unchanged.

Test Plan:
- Left-justified, WIDTH=16, clk = 8x BCLK, send L=16'hA5C3, R=16'h0F01 → left_sample=A5C3, right_sample=0F01, one sample_end[1] pulse, then one sample_end[0] pulse plus sample_valid, frame_err=0.
- I2S_DELAY=1, L=16'h8001, R=16'h7FFE with the 1-bit delay → same values captured; a stray leading bit is not shifted in.
- 32 BCLKs per channel (16 padding bits of 1s) with L=16'h1234 → left_sample=1234; padding is ignored and no extra pulses occur.
- Truncate right word after 10 bits, then send a good frame L=16'h0001, R=16'h0002:
  - frame_err=1 and right_sample holds its previous value.
  - The next frame is captured correctly.
  - err_count=1 when the macro is defined.
- Assert reset_n low mid-left-word, release it, send L=16'hFFFF, R=16'h0000:
  - All outputs are 0 during reset.
  - The first LRCK edge after release is used only for sync, so no word is output before the next complete channel.
- err_clear asserted in the same cycle as a short-frame event → frame_err=0.
- Drive 300 short frames → err_count saturates at 255 (macro defined).
